// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine: single-MAC square matrix multiplier (C = A*B or C += A*B)
// with internal A/B/C buffers behind a word-addressed bus-slave register map.
module matrix_mac_engine #(
    parameter int DW = 16,
    parameter int N  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        S_sel,
    input  logic        S_wr,
    input  logic [7:0]  S_address,
    input  logic [31:0] S_din,
    output logic [31:0] S_dout,
    output logic        m_interrupt,
    output logic        busy
);
    localparam int         NN   = N * N;
    localparam int         AW   = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [6:0] NN7  = 7'(NN);
    localparam logic [3:0] NMAX = 4'(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [DW-1:0] a_mem [NN];
    logic [DW-1:0] b_mem [NN];
    logic [31:0]   c_mem [NN];

    logic          ctrl_signed, ctrl_accum, ctrl_ie;
    logic          done, err;
    logic [3:0]    dim;
    logic          run_signed, run_accum;
    logic [3:0]    run_n;
    logic [3:0]    i, j, k;
    logic [31:0]   acc;

    // decoded bus strobes and address fields
    logic          wr, rd;
    logic          wr_ctrl, wr_status, wr_dim, wr_a, wr_b;
    logic [5:0]    off;
    logic          in_range;
    logic [AW-1:0] off_idx;
    logic [31:0]   rd_data;

    // datapath
    logic [AW-1:0] a_idx, b_idx, c_idx, nxt_idx;
    logic [DW-1:0] a_op, b_op;
    logic [31:0]   a_ext, b_ext, product;
    logic          last_col, last_row;
    logic [3:0]    nxt_i, nxt_j;
    logic          dim_ok;
    logic          unused_din;

    assign unused_din = ^S_din;

    // address decode, read mux and MAC operand selection
    always_comb begin
        wr        = S_sel & S_wr;
        rd        = S_sel & ~S_wr;
        off       = S_address[5:0];
        in_range  = ({1'b0, off} < NN7);
        off_idx   = off[AW-1:0];
        wr_ctrl   = wr && (S_address == 8'h00);
        wr_status = wr && (S_address == 8'h01);
        wr_dim    = wr && (S_address == 8'h02);
        wr_a      = wr && (S_address[7:6] == 2'b01) && in_range;
        wr_b      = wr && (S_address[7:6] == 2'b10) && in_range;
        dim_ok    = (dim != 4'd0) && (dim <= NMAX);

        rd_data = '0;
        case (S_address[7:6])
            2'b00: begin
                case (S_address[5:0])
                    6'h00:   rd_data = {27'd0, ctrl_ie, ctrl_accum, ctrl_signed, 2'b00};
                    6'h01:   rd_data = {29'd0, err, done, busy};
                    6'h02:   rd_data = {28'd0, dim};
                    default: rd_data = '0;
                endcase
            end
            2'b01: if (in_range) rd_data = ctrl_signed ?
                       {{(32-DW){a_mem[off_idx][DW-1]}}, a_mem[off_idx]} :
                       {{(32-DW){1'b0}}, a_mem[off_idx]};
            2'b10: if (in_range) rd_data = ctrl_signed ?
                       {{(32-DW){b_mem[off_idx][DW-1]}}, b_mem[off_idx]} :
                       {{(32-DW){1'b0}}, b_mem[off_idx]};
            default: if (in_range) rd_data = c_mem[off_idx];
        endcase

        a_idx    = AW'(int'(i) * N + int'(k));
        b_idx    = AW'(int'(k) * N + int'(j));
        c_idx    = AW'(int'(i) * N + int'(j));
        last_col = (j == run_n - 4'd1);
        last_row = (i == run_n - 4'd1);
        nxt_i    = last_col ? i + 4'd1 : i;
        nxt_j    = last_col ? 4'd0 : j + 4'd1;
        nxt_idx  = AW'(int'(nxt_i) * N + int'(nxt_j));

        a_op  = a_mem[a_idx];
        b_op  = b_mem[b_idx];
        a_ext = run_signed ? {{(32-DW){a_op[DW-1]}}, a_op} : {{(32-DW){1'b0}}, a_op};
        b_ext = run_signed ? {{(32-DW){b_op[DW-1]}}, b_op} : {{(32-DW){1'b0}}, b_op};
        // low 32 bits of the extended-operand product equal the 2*DW product extended to 32
        product = a_ext * b_ext;

        busy = (state != S_IDLE);
    end

    // control registers, buffers and the MAC sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ctrl_signed <= 1'b0;
            ctrl_accum  <= 1'b0;
            ctrl_ie     <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            dim         <= '0;
            run_signed  <= 1'b0;
            run_accum   <= 1'b0;
            run_n       <= '0;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            acc         <= '0;
            for (int unsigned x = 0; x < NN; x++) begin
                a_mem[x] <= '0;
                b_mem[x] <= '0;
                c_mem[x] <= '0;
            end
        end else begin
            if (wr_status) begin
                if (S_din[1]) done <= 1'b0;
                if (S_din[2]) err  <= 1'b0;
            end
            if (wr_ctrl) begin
                ctrl_signed <= S_din[2];
                ctrl_accum  <= S_din[3];
                ctrl_ie     <= S_din[4];
            end
            if (!busy) begin
                if (wr_dim) dim <= S_din[3:0];
                if (wr_a)   a_mem[off_idx] <= S_din[DW-1:0];
                if (wr_b)   b_mem[off_idx] <= S_din[DW-1:0];
            end

            if (wr_ctrl && S_din[1]) begin
                // clear/abort: overrides any start in the same write
                state <= S_IDLE;
                acc   <= '0;
                done  <= 1'b0;
                err   <= 1'b0;
                for (int unsigned x = 0; x < NN; x++) c_mem[x] <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (wr_ctrl && S_din[0]) begin
                            if (dim_ok) begin
                                state      <= S_MAC;
                                run_signed <= S_din[2];
                                run_accum  <= S_din[3];
                                run_n      <= dim;
                                i          <= '0;
                                j          <= '0;
                                k          <= '0;
                                acc        <= S_din[3] ? c_mem[0] : '0;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    S_MAC: begin
                        acc <= acc + product;
                        if (k == run_n - 4'd1) begin
                            k     <= '0;
                            state <= S_WB;
                        end else begin
                            k <= k + 4'd1;
                        end
                    end
                    S_WB: begin
                        c_mem[c_idx] <= acc;
                        if (last_col && last_row) begin
                            state <= S_DONE;
                        end else begin
                            i     <= nxt_i;
                            j     <= nxt_j;
                            acc   <= run_accum ? c_mem[nxt_idx] : '0;
                            state <= S_MAC;
                        end
                    end
                    default: begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // registered read data: updated only on a read access
    always_ff @(posedge clk) begin
        if (reset)   S_dout <= '0;
        else if (rd) S_dout <= rd_data;
    end

    // level interrupt from the stored done flag and IE
    always_ff @(posedge clk) begin
        if (reset) m_interrupt <= 1'b0;
        else       m_interrupt <= done & ctrl_ie;
    end
endmodule

// File: tb/tb_matrix_mac_engine.sv
// tb_matrix_mac_engine: register-map vectors, directed corner sequences and
// randomized runs checked against a plain-arithmetic matrix model.
module tb_matrix_mac_engine;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int NN = N * N;

    logic        clk = 1'b0;
    logic        reset;
    logic        S_sel, S_wr;
    logic [7:0]  S_address;
    logic [31:0] S_din, S_dout;
    logic        m_interrupt, busy;

    int unsigned n_cmp = 0, n_bad = 0, cyc = 0, start_cyc = 0;
    logic [DW-1:0] ma [NN];
    logic [DW-1:0] mb [NN];
    logic [31:0]   mc [NN];

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [12];

    matrix_mac_engine #(.DW(DW), .N(N)) dut (
        .clk(clk), .reset(reset), .S_sel(S_sel), .S_wr(S_wr),
        .S_address(S_address), .S_din(S_din), .S_dout(S_dout),
        .m_interrupt(m_interrupt), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        S_sel = 1'b1; S_wr = 1'b1; S_address = a; S_din = d;
        @(posedge clk); #1;
        S_sel = 1'b0; S_wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        S_sel = 1'b1; S_wr = 1'b0; S_address = a;
        @(posedge clk); #1;
        S_sel = 1'b0;
        d = S_dout;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        check(name, d, exp);
    endtask

    task automatic start(input logic [31:0] ctrl);
        bus_wr(8'h00, ctrl | 32'h1);
        start_cyc = cyc;
    endtask

    task automatic wait_done(output int unsigned lat);
        lat = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (!busy) begin
                lat = cyc - start_cyc;
                return;
            end
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_done: busy still 1 after 400 cycles, required 0");
    endtask

    task automatic load(input bit is_b, input int idx, input logic [DW-1:0] v);
        bus_wr(8'(is_b ? 128 + idx : 64 + idx), {16'd0, v});
        if (is_b) mb[idx] = v; else ma[idx] = v;
    endtask

    // C[i][j] = (accum ? C[i][j] : 0) + sum_k A[i][k]*B[k][j], modulo 2^32
    function automatic void model_run(input int n, input bit sgn, input bit accum);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                longint s = accum ? longint'(mc[r*N+c]) : 64'sd0;
                for (int q = 0; q < n; q++) begin
                    longint av = sgn ? longint'($signed(ma[r*N+q])) : longint'(ma[r*N+q]);
                    longint bv = sgn ? longint'($signed(mb[q*N+c])) : longint'(mb[q*N+c]);
                    s += av * bv;
                end
                mc[r*N+c] = s[31:0];
            end
    endfunction

    initial begin
        int unsigned lat;
        logic [31:0] d;

        tbl[0]  = '{1'b1, 8'h40, 32'h0000_1234, 32'h0000_1234};
        tbl[1]  = '{1'b1, 8'h4F, 32'h0000_FFFF, 32'h0000_FFFF};
        tbl[2]  = '{1'b1, 8'h85, 32'h1234_5678, 32'h0000_5678};
        tbl[3]  = '{1'b1, 8'h02, 32'h0000_0003, 32'h0000_0003};
        tbl[4]  = '{1'b1, 8'hC0, 32'h0000_DEAD, 32'h0000_0000};
        tbl[5]  = '{1'b1, 8'hFF, 32'h0000_0005, 32'h0000_0000};
        tbl[6]  = '{1'b1, 8'h50, 32'h0000_0007, 32'h0000_0000};
        tbl[7]  = '{1'b1, 8'h00, 32'h0000_000C, 32'h0000_000C};
        tbl[8]  = '{1'b0, 8'h4F, 32'h0,         32'hFFFF_FFFF};
        tbl[9]  = '{1'b1, 8'h00, 32'h0000_0000, 32'h0000_0000};
        tbl[10] = '{1'b0, 8'h4F, 32'h0,         32'h0000_FFFF};
        tbl[11] = '{1'b0, 8'h01, 32'h0,         32'h0000_0000};

        S_sel = 1'b0; S_wr = 1'b0; S_address = '0; S_din = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;

        check("rst_dout", S_dout, 32'h0);
        check("rst_irq", {31'd0, m_interrupt}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        rd_chk("rst_ctrl", 8'h00, 32'h0);
        rd_chk("rst_dim", 8'h02, 32'h0);
        rd_chk("rst_c0", 8'hC0, 32'h0);

        for (int v = 0; v < 12; v++) begin
            if (tbl[v].wr) bus_wr(tbl[v].addr, tbl[v].data);
            bus_rd(tbl[v].addr, d);
            check($sformatf("vec%0d_addr%02h", v, tbl[v].addr), d, tbl[v].exp);
        end

        // n=2 unsigned reference example with interrupt
        for (int x = 0; x < NN; x++) begin load(1'b0, x, '0); load(1'b1, x, '0); end
        load(1'b0, 0, 1); load(1'b0, 1, 2); load(1'b0, 4, 3); load(1'b0, 5, 4);
        load(1'b1, 0, 5); load(1'b1, 1, 6); load(1'b1, 4, 7); load(1'b1, 5, 8);
        bus_wr(8'h02, 32'd2);
        start(32'h10);
        wait_done(lat);
        check("n2_latency", lat, 32'd13);
        check("n2_irq_lag", {31'd0, m_interrupt}, 32'h0);
        @(posedge clk); #1;
        check("n2_irq", {31'd0, m_interrupt}, 32'h1);
        rd_chk("n2_status", 8'h01, 32'h2);
        rd_chk("n2_c00", 8'hC0, 32'd19);
        rd_chk("n2_c01", 8'hC1, 32'd22);
        rd_chk("n2_c10", 8'hC4, 32'd43);
        rd_chk("n2_c11", 8'hC5, 32'd50);
        bus_wr(8'h01, 32'h2);
        rd_chk("n2_w1c", 8'h01, 32'h0);
        check("n2_irq_drop", {31'd0, m_interrupt}, 32'h0);

        // accumulate twice from a cleared C
        bus_wr(8'h00, 32'h2);
        start(32'h08); wait_done(lat);
        start(32'h08); wait_done(lat);
        rd_chk("acc_c00", 8'hC0, 32'd38);
        rd_chk("acc_c01", 8'hC1, 32'd44);
        rd_chk("acc_c10", 8'hC4, 32'd86);
        rd_chk("acc_c11", 8'hC5, 32'd100);

        // signed 1x1
        load(1'b0, 0, 16'hFFFF); load(1'b1, 0, 16'd3);
        bus_wr(8'h02, 32'd1);
        start(32'h04);
        wait_done(lat);
        check("sgn_latency", lat, 32'd3);
        rd_chk("sgn_c00", 8'hC0, 32'hFFFF_FFFD);
        bus_wr(8'h01, 32'h2);

        // size errors: n=0 and n=N+1
        for (int t = 0; t < 2; t++) begin
            bus_wr(8'h02, (t == 0) ? 32'd0 : 32'(N + 1));
            bus_wr(8'h00, 32'h1);
            check($sformatf("err%0d_busy", t), {31'd0, busy}, 32'h0);
            rd_chk($sformatf("err%0d_status", t), 8'h01, 32'h4);
            rd_chk($sformatf("err%0d_c00", t), 8'hC0, 32'hFFFF_FFFD);
            bus_wr(8'h01, 32'h4);
            rd_chk($sformatf("err%0d_w1c", t), 8'h01, 32'h0);
        end

        // abort an n=4 run with clear
        bus_wr(8'h02, 32'd4);
        start(32'h10);
        repeat (9) @(posedge clk);
        bus_wr(8'h00, 32'h12);
        check("abort_busy", {31'd0, busy}, 32'h0);
        rd_chk("abort_status", 8'h01, 32'h0);
        check("abort_irq", {31'd0, m_interrupt}, 32'h0);
        for (int x = 0; x < NN; x++) begin
            mc[x] = '0;
            rd_chk($sformatf("abort_c%0d", x), 8'(192 + x), 32'h0);
        end
        load(1'b0, 0, 16'h0055);
        rd_chk("abort_awr", 8'h40, 32'h55);

        // randomized runs against the model, with bus traffic while busy
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, N);
            bit sgn = 1'($urandom_range(0, 1));
            bit accm = 1'($urandom_range(0, 1));
            logic [31:0] exp_a1;
            for (int x = 0; x < NN; x++) begin
                load(1'b0, x, DW'($urandom));
                load(1'b1, x, DW'($urandom));
            end
            bus_wr(8'h02, 32'(n));
            bus_wr(8'h01, 32'h2);
            start({27'd0, 1'b1, accm, sgn, 2'b00});
            if (n >= 2) begin
                bus_wr(8'h41, {16'd0, ~ma[1]});
                bus_wr(8'h02, 32'd7);
                rd_chk($sformatf("rnd%0d_busy_status", r), 8'h01, 32'h1);
                rd_chk($sformatf("rnd%0d_rd_ff", r), 8'hFF, 32'h0);
                rd_chk($sformatf("rnd%0d_rd_oor", r), 8'(80 + NN), 32'h0);
            end
            wait_done(lat);
            check($sformatf("rnd%0d_latency", r), lat, 32'(n * n * (n + 1) + 1));
            model_run(n, sgn, accm);
            for (int x = 0; x < NN; x++)
                rd_chk($sformatf("rnd%0d_c%0d", r, x), 8'(192 + x), mc[x]);
            exp_a1 = sgn ? 32'($signed(ma[1])) : {16'd0, ma[1]};
            rd_chk($sformatf("rnd%0d_a1", r), 8'h41, exp_a1);
            rd_chk($sformatf("rnd%0d_dim", r), 8'h02, 32'(n));
        end

        // reset in the middle of a run
        bus_wr(8'h02, 32'd4);
        start(32'h10);
        repeat (5) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); reset = 1'b0;
        check("mrst_busy", {31'd0, busy}, 32'h0);
        check("mrst_irq", {31'd0, m_interrupt}, 32'h0);
        check("mrst_dout", S_dout, 32'h0);
        rd_chk("mrst_a0", 8'h40, 32'h0);
        rd_chk("mrst_c0", 8'hC0, 32'h0);
        rd_chk("mrst_dim", 8'h02, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
